// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF challenge sequencer: runs NBITS races through the counter group and packs the decisions.
// Optional per-race timeout is compiled in with `define PUF_TIMEOUT_EN.
`timescale 1ns/1ps
module puf_challenge_sequencer #(
    parameter int NBITS          = 8,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [8*NBITS-1:0] challenge,
    input  logic               cg_done,
    input  logic               cg_response,
    output logic [3:0]         cha0,
    output logic [3:0]         cha1,
    output logic               cg_reset,
    output logic               busy,
    output logic               resp_valid,
    output logic [NBITS-1:0]   response,
    output logic               same_err,
    output logic               timeout_err,
    output logic [2:0]         state_dbg
);

    // Handshake: start is a request taken only in IDLE (no queueing); resp_valid is a
    // one-cycle completion pulse with no back-pressure, response/flags hold until next start.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RACE_RST = 3'd1,
        S_RACE_RUN = 3'd2,
        S_NEXT     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);
    localparam logic [RW-1:0] LAST_RST = RW'(RST_CYCLES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [NBITS-1:0][7:0]  chal_q;
    logic [IW-1:0]          idx;
    logic [RW-1:0]          rst_cnt;
    logic                   done_s1, done_s2;
    logic                   resp_s1, resp_s2;
    logic                   pair_same;
    logic                   rst_elapsed;
    logic                   race_timeout;

    assign cha0        = chal_q[idx][3:0];
    assign cha1        = chal_q[idx][7:4];
    assign pair_same   = (cha0 == cha1);
    assign rst_elapsed = (rst_cnt == LAST_RST);
    assign state_dbg   = state;

    // Counter-group flags come from the ring-oscillator domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            resp_s1 <= 1'b0;
            resp_s2 <= 1'b0;
        end else begin
            done_s1 <= cg_done;
            done_s2 <= done_s1;
            resp_s1 <= cg_response;
            resp_s2 <= resp_s1;
        end
    end

`ifdef PUF_TIMEOUT_EN
    logic [19:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state != S_RACE_RUN) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
        end
    end

    assign race_timeout = (state == S_RACE_RUN) && !done_s2 &&
                          (tmo_cnt == 20'(TIMEOUT_CYCLES - 1));
`else
    assign race_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RACE_RST also waits for the previous decision flag to drop before relaunching.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RACE_RST;
            end
            S_RACE_RST: begin
                if (rst_elapsed) begin
                    if (pair_same)     state_nxt = S_NEXT;
                    else if (!done_s2) state_nxt = S_RACE_RUN;
                end
            end
            S_RACE_RUN: begin
                if (done_s2 || race_timeout) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = (idx == LAST_IDX) ? S_DONE : S_RACE_RST;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        cg_reset   = 1'b1;
        resp_valid = 1'b0;
        case (state)
            S_IDLE:     busy = 1'b0;
            S_RACE_RUN: cg_reset = 1'b0;
            S_DONE: begin
                busy       = 1'b0;
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt <= '0;
        end else if (state != S_RACE_RST) begin
            rst_cnt <= '0;
        end else if (!rst_elapsed) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chal_q      <= '0;
            idx         <= '0;
            response    <= '0;
            same_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_q      <= challenge;
                        idx         <= '0;
                        response    <= '0;
                        same_err    <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                S_RACE_RST: begin
                    if (rst_elapsed && pair_same) begin
                        same_err      <= 1'b1;
                        response[idx] <= 1'b0;
                    end
                end
                S_RACE_RUN: begin
                    if (done_s2) begin
                        response[idx] <= resp_s2;
                    end else if (race_timeout) begin
                        response[idx] <= 1'b0;
                        timeout_err   <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                S_DONE: begin
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: emulated counter group with random race times, reference
// response computed from a random oscillator-frequency table.
`timescale 1ns/1ps
module tb_puf_challenge_sequencer;

    localparam int NBITS      = 8;
    localparam int RST_CYCLES = 4;
    localparam int TMO        = 100;
    localparam logic [63:0] CHAL_SEQ  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] CHAL_SAME = 64'hFEDC_BA98_7655_3210;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [8*NBITS-1:0] challenge;
    logic               cg_done;
    logic               cg_response;
    logic [3:0]         cha0, cha1;
    logic               cg_reset, busy, resp_valid;
    logic [NBITS-1:0]   response;
    logic               same_err, timeout_err;
    logic [2:0]         state_dbg;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          freq[16];
    bit          hold_mode = 1'b0;
    bit          hang_once = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  race_log[$];
    logic [7:0]  er;
    logic        es;
    int          cyc;

    puf_challenge_sequencer #(
        .NBITS(NBITS), .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .cg_done(cg_done), .cg_response(cg_response), .cha0(cha0), .cha1(cha1),
        .cg_reset(cg_reset), .busy(busy), .resp_valid(resp_valid), .response(response),
        .same_err(same_err), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counter-group emulation: decision arrives asynchronously after a random race time.
    always begin
        @(negedge cg_reset);
        race_log.push_back({cha0, cha1});
        if (hang_once) begin
            hang_once = 1'b0;
        end else begin
            #($urandom_range(3, 60));
            if (!cg_reset) begin
                cg_response = (freq[cha0] > freq[cha1]);
                #1 cg_done = 1'b1;
            end
        end
        if (!cg_reset) @(posedge cg_reset);
        while (hold_mode) @(negedge clk);
        #($urandom_range(3, 60));
        cg_done = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: bit i = 1 when Cha0's oscillator beats Cha1's; equal pair gives 0 and no race.
    function automatic void model(input logic [63:0] chal, output logic [7:0] r, output logic s);
        logic [3:0] c0, c1;
        r = '0;
        s = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NBITS; i++) begin
            c0 = chal[8*i +: 4];
            c1 = chal[8*i+4 +: 4];
            if (c0 == c1) begin
                s = 1'b1;
            end else begin
                r[i] = (freq[c0] > freq[c1]);
                exp_q.push_back({c0, c1});
            end
        end
    endfunction

    task automatic check_races();
        chk("race_count", race_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < race_log.size(); i++)
            chk($sformatf("race_ch[%0d]", i), race_log[i], exp_q[i]);
    endtask

    task automatic start_eval(input logic [63:0] chal);
        race_log.delete();
        @(negedge clk);
        challenge = chal;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic run_eval(input logic [63:0] chal, input bit disturb, input bit hold);
        logic [7:0] exp_r;
        logic       exp_s;
        int         c;
        int         first_low;
        int         stuck;
        bit         seen;
        bit         held;
        model(chal, exp_r, exp_s);
        hold_mode = hold;
        start_eval(chal);
        chk("busy_rise", busy, 1);
        chk("resp_cleared", response, 0);
        c = 1; first_low = -1; seen = 0; held = 0;
        while (!seen && c < 4000) begin
            if (first_low < 0 && !cg_reset) first_low = c;
            if (hold && !held && race_log.size() == 1 && cg_reset) begin
                stuck = 0;
                repeat (20) begin
                    @(negedge clk);
                    c++;
                    if (cg_reset) stuck++;
                end
                chk("hold_stuck", stuck, 20);
                chk("hold_races", race_log.size(), 1);
                hold_mode = 1'b0;
                held = 1;
            end else if (resp_valid) begin
                seen = 1;
            end else begin
                if (disturb) begin
                    start = (c % 5 == 2);
                    if (c % 9 == 4) challenge = {$urandom, $urandom};
                end
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        hold_mode = 1'b0;
        chk("resp_valid_seen", seen, 1);
        if (chal[3:0] != chal[7:4]) chk("rst_len", first_low, RST_CYCLES + 1);
        chk("response", response, exp_r);
        chk("same_err", same_err, exp_s);
        chk("timeout_err", timeout_err, 0);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("resp_valid_pulse", resp_valid, 0);
        chk("response_held", response, exp_r);
        check_races();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; challenge = '0; cg_done = 1'b0; cg_response = 1'b0;
        for (int i = 0; i < 16; i++) freq[i] = int'($urandom_range(0, 1000)) * 16 + i;
        repeat (3) @(negedge clk);
        chk("rst_cha0", cha0, 0);
        chk("rst_cha1", cha1, 0);
        chk("rst_cg_reset", cg_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_response", response, 0);
        chk("rst_same_err", same_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // distinct-nibble sequence, then an equal pair at index 2
        run_eval(CHAL_SEQ, 0, 0);
        run_eval(CHAL_SAME, 0, 0);
        // start pulses and challenge changes while busy
        run_eval(CHAL_SEQ ^ 64'h0F0F_0F0F_0F0F_0F0F, 1, 0);
        // decision flag held high across the race boundary
        run_eval(CHAL_SEQ, 0, 1);
        for (int i = 0; i < 5; i++) run_eval({$urandom, $urandom}, i[0], 0);

        // asynchronous abort during race 4
        model(CHAL_SEQ, er, es);
        start_eval(CHAL_SEQ);
        cyc = 0;
        while (race_log.size() < 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_race4", race_log.size(), 5);
        #2 reset = 1'b0;
        #1;
        chk("abort_cg_reset", cg_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_response", response, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_cha0", cha0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        run_eval(CHAL_SEQ, 0, 0);

        // counter group never answers race 0
        model(CHAL_SEQ, er, es);
        hang_once = 1'b1;
        start_eval(CHAL_SEQ);
`ifdef PUF_TIMEOUT_EN
        er[0] = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_resp_valid", resp_valid, 1);
        chk("tmo_response", response, er);
        chk("tmo_timeout_err", timeout_err, 1);
        repeat (10) @(negedge clk);
`else
        repeat (300) @(negedge clk);
        chk("hang_busy", busy, 1);
        chk("hang_cg_reset", cg_reset, 0);
        chk("hang_races", race_log.size(), 1);
        chk("hang_timeout_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
`endif
        run_eval(CHAL_SAME, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
